// File: rtl/pred_npc_gen_if.sv
// Fetch-PC generator port bundle: BTB lookup side, redirect inputs and IF-stage group output.
// master = pred_npc_gen, slave = the BTB/IF/backend side that drives the lookup results and redirects.
interface pred_npc_gen_if #(
    parameter int BTBIDLEN = 5
);
    logic [31:0]         fetch_pc;
    logic                hit_0;
    logic                hit_1;
    logic [31:0]         target_0;
    logic [31:0]         target_1;
    logic [BTBIDLEN-1:0] index_0;
    logic [BTBIDLEN-1:0] index_1;
    logic                flush_valid;
    logic [31:0]         flush_target;
    logic                branch_mistaken;
    logic [31:0]         right_target;
    logic                if_ready;
    logic                if_valid;
    logic [31:0]         if_pc;
    logic [1:0]          if_inst_valid;
    logic [1:0]          if_pred_taken;
    logic [31:0]         if_pred_target;
    logic [BTBIDLEN-1:0] if_pred_index;

    modport master (
        output fetch_pc, if_valid, if_pc, if_inst_valid, if_pred_taken, if_pred_target, if_pred_index,
        input  hit_0, hit_1, target_0, target_1, index_0, index_1,
        input  flush_valid, flush_target, branch_mistaken, right_target, if_ready
    );

    modport slave (
        input  fetch_pc, if_valid, if_pc, if_inst_valid, if_pred_taken, if_pred_target, if_pred_index,
        output hit_0, hit_1, target_0, target_1, index_0, index_1,
        output flush_valid, flush_target, branch_mistaken, right_target, if_ready
    );
endinterface

// File: rtl/pred_npc_gen.sv
// Next-fetch-PC generator with 2-slot BTB prediction (prediction enabled by macro BTB_PRED_EN).
// Latency: fetch_pc is pc_q directly; the group looked up this cycle appears on if_* next cycle.
// Backpressure: if_valid & !if_ready holds pc_q and all if_*; redirects override regardless of if_ready.
module pred_npc_gen #(
    parameter int          BTBNUM   = 32,
    parameter int          BTBIDLEN = $clog2(BTBNUM),
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input logic           clk,
    input logic           reset,
    pred_npc_gen_if.master bus
);
    // A single-entry BTB still carries a 1-bit index.
    localparam int IDX_W = (BTBNUM > 1) ? BTBIDLEN : 1;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_REDIR
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [1:0]         if_inst_valid_q, if_inst_valid_d;
    logic [1:0]         if_pred_taken_q, if_pred_taken_d;
    logic [31:0]        if_pred_target_q, if_pred_target_d;
    logic [IDX_W-1:0]   if_pred_index_q, if_pred_index_d;

    logic               launch;
    logic [31:0]        nxt_pc;
    logic [1:0]         nxt_inst_valid;
    logic [1:0]         nxt_pred_taken;
    logic [31:0]        nxt_pred_target;
    logic [IDX_W-1:0]   nxt_pred_index;

    // Group contents and successor PC for the lookup currently on fetch_pc.
    always_comb begin
        nxt_pc          = pc_q + 32'd8;
        nxt_inst_valid  = 2'b11;
        nxt_pred_taken  = 2'b00;
        nxt_pred_target = 32'd0;
        nxt_pred_index  = '0;
`ifdef BTB_PRED_EN
        if (bus.hit_0) begin
            nxt_pc          = {bus.target_0[31:2], 2'b00};
            nxt_inst_valid  = 2'b01;
            nxt_pred_taken  = 2'b01;
            nxt_pred_target = bus.target_0;
            nxt_pred_index  = bus.index_0;
        end else if (bus.hit_1) begin
            nxt_pc          = {bus.target_1[31:2], 2'b00};
            nxt_inst_valid  = 2'b11;
            nxt_pred_taken  = 2'b10;
            nxt_pred_target = bus.target_1;
            nxt_pred_index  = bus.index_1;
        end
`endif
    end

`ifndef BTB_PRED_EN
    logic btb_unused;
    assign btb_unused = ^{bus.hit_0, bus.hit_1, bus.target_0, bus.target_1, bus.index_0, bus.index_1};
`endif

    assign launch = (state_q == S_RUN) && (!if_valid_q || bus.if_ready);

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_valid_d       = if_valid_q;
        if_pc_d          = if_pc_q;
        if_inst_valid_d  = if_inst_valid_q;
        if_pred_taken_d  = if_pred_taken_q;
        if_pred_target_d = if_pred_target_q;
        if_pred_index_d  = if_pred_index_q;

        // Redirects win in every state; the lookup in flight is dropped.
        if (bus.flush_valid) begin
            pc_d       = {bus.flush_target[31:2], 2'b00};
            if_valid_d = 1'b0;
            state_d    = S_REDIR;
        end else if (bus.branch_mistaken) begin
            pc_d       = {bus.right_target[31:2], 2'b00};
            if_valid_d = 1'b0;
            state_d    = S_REDIR;
        end else begin
            case (state_q)
                S_BOOT:  state_d = S_RUN;
                S_REDIR: state_d = S_RUN;
                S_RUN: begin
                    if (launch) begin
                        if_valid_d       = 1'b1;
                        if_pc_d          = pc_q;
                        pc_d             = nxt_pc;
                        if_inst_valid_d  = nxt_inst_valid;
                        if_pred_taken_d  = nxt_pred_taken;
                        if_pred_target_d = nxt_pred_target;
                        if_pred_index_d  = nxt_pred_index;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_BOOT;
            pc_q             <= RESET_PC;
            if_valid_q       <= 1'b0;
            if_pc_q          <= 32'd0;
            if_inst_valid_q  <= 2'b00;
            if_pred_taken_q  <= 2'b00;
            if_pred_target_q <= 32'd0;
            if_pred_index_q  <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_valid_q       <= if_valid_d;
            if_pc_q          <= if_pc_d;
            if_inst_valid_q  <= if_inst_valid_d;
            if_pred_taken_q  <= if_pred_taken_d;
            if_pred_target_q <= if_pred_target_d;
            if_pred_index_q  <= if_pred_index_d;
        end
    end

    assign bus.fetch_pc       = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_inst_valid  = if_inst_valid_q;
    assign bus.if_pred_taken  = if_pred_taken_q;
    assign bus.if_pred_target = if_pred_target_q;
    assign bus.if_pred_index  = if_pred_index_q;
endmodule

// File: tb/tb_pred_npc_gen.sv
// Bench for pred_npc_gen: directed literal sequence, then random traffic against a group-stream model.
module tb_pred_npc_gen;
    localparam int IDW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pred_npc_gen_if #(.BTBIDLEN(IDW)) bus ();

    pred_npc_gen #(
        .BTBNUM(32),
        .BTBIDLEN(IDW),
        .RESET_PC(32'h1c000000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the PC that will be looked up, the last group handed to IF,
    // and how many silent cycles remain before a group may be launched.
    logic [31:0] m_pc;
    int          m_gap;
    logic        m_vld;
    logic [31:0] m_ifpc;
    logic [1:0]  m_inst;
    logic [1:0]  m_taken;
    logic [31:0] m_tgt;
    logic [31:0] m_idx;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h1c000000; m_gap = 1; m_vld = 1'b0;
            m_ifpc = 0; m_inst = 0; m_taken = 0; m_tgt = 0; m_idx = 0;
            chk_en = 1'b1;
        end else if (bus.flush_valid || bus.branch_mistaken) begin
            m_pc  = (bus.flush_valid ? bus.flush_target : bus.right_target) & 32'hFFFF_FFFC;
            m_vld = 1'b0;
            m_gap = 1;
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else if (!m_vld || bus.if_ready) begin
            m_vld = 1'b1;
            m_ifpc = m_pc;
            m_inst = 2'b11; m_taken = 2'b00; m_tgt = 0; m_idx = 0;
            m_pc = m_pc + 32'd8;
`ifdef BTB_PRED_EN
            if (bus.hit_0) begin
                m_inst = 2'b01; m_taken = 2'b01; m_tgt = bus.target_0; m_idx = 32'(bus.index_0);
                m_pc = bus.target_0 & 32'hFFFF_FFFC;
            end else if (bus.hit_1) begin
                m_taken = 2'b10; m_tgt = bus.target_1; m_idx = 32'(bus.index_1);
                m_pc = bus.target_1 & 32'hFFFF_FFFC;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("fetch_pc",       bus.fetch_pc,             m_pc);
            check("if_valid",       32'(bus.if_valid),        32'(m_vld));
            check("if_pc",          bus.if_pc,                m_ifpc);
            check("if_inst_valid",  32'(bus.if_inst_valid),   32'(m_inst));
            check("if_pred_taken",  32'(bus.if_pred_taken),   32'(m_taken));
            check("if_pred_target", bus.if_pred_target,       m_tgt);
            check("if_pred_index",  32'(bus.if_pred_index),   m_idx);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.hit_0 = 0; bus.hit_1 = 0; bus.target_0 = 0; bus.target_1 = 0;
        bus.index_0 = 0; bus.index_1 = 0;
        bus.flush_valid = 0; bus.flush_target = 0;
        bus.branch_mistaken = 0; bus.right_target = 0;
    endtask

    logic [31:0] stall_pc;

    initial begin
        reset = 1'b1;
        clear_inputs();
        bus.if_ready = 1'b1;
`ifdef BTB_PRED_EN
        stall_pc = 32'h1c000200;
`else
        stall_pc = 32'h1c000020;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lit_rst_valid", 32'(bus.if_valid), 32'd0);
        check("lit_rst_ifpc",  bus.if_pc,         32'd0);
        check("lit_rst_fetch", bus.fetch_pc,      32'h1c000000);
        reset = 1'b0;

        tick(); check("lit_boot_valid", 32'(bus.if_valid), 32'd0);
        tick(); check("lit_first_valid", 32'(bus.if_valid), 32'd1);
                check("lit_seq0", bus.if_pc, 32'h1c000000);
        tick(); check("lit_seq1", bus.if_pc, 32'h1c000008);
        bus.hit_0 = 1; bus.target_0 = 32'h1c000100; bus.index_0 = 5'd5;
        tick(); check("lit_seq2", bus.if_pc, 32'h1c000010);
`ifdef BTB_PRED_EN
        check("lit_hit0_inst",  32'(bus.if_inst_valid), 32'h1);
        check("lit_hit0_taken", 32'(bus.if_pred_taken), 32'h1);
        check("lit_hit0_index", 32'(bus.if_pred_index), 32'd5);
        check("lit_hit0_tgt",   bus.if_pred_target,      32'h1c000100);
`else
        check("lit_nohit_inst",  32'(bus.if_inst_valid), 32'h3);
        check("lit_nohit_taken", 32'(bus.if_pred_taken), 32'h0);
        check("lit_nohit_index", 32'(bus.if_pred_index), 32'd0);
`endif
        bus.hit_0 = 0; bus.hit_1 = 1; bus.target_1 = 32'h1c000200; bus.index_1 = 5'd9;
        tick();
`ifdef BTB_PRED_EN
        check("lit_hit0_next", bus.if_pc, 32'h1c000100);
        check("lit_hit1_inst",  32'(bus.if_inst_valid), 32'h3);
        check("lit_hit1_taken", 32'(bus.if_pred_taken), 32'h2);
`else
        check("lit_seq3", bus.if_pc, 32'h1c000018);
        check("lit_nohit1_taken", 32'(bus.if_pred_taken), 32'h0);
`endif
        clear_inputs();
        tick(); check("lit_hit1_next", bus.if_pc, stall_pc);

        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_stall_ifpc",  bus.if_pc,          stall_pc);
            check("lit_stall_fetch", bus.fetch_pc,       stall_pc + 32'd8);
            check("lit_stall_valid", 32'(bus.if_valid),  32'd1);
        end
        bus.if_ready = 1'b1;
        tick(); check("lit_resume", bus.if_pc, stall_pc + 32'd8);

        bus.flush_valid = 1; bus.flush_target = 32'h1c008000;
        bus.branch_mistaken = 1; bus.right_target = 32'h1c000400;
        tick(); check("lit_redir_valid", 32'(bus.if_valid), 32'd0);
                check("lit_redir_fetch", bus.fetch_pc, 32'h1c008000);
        clear_inputs();
        tick(); check("lit_bubble_valid", 32'(bus.if_valid), 32'd0);
        tick(); check("lit_redir_ifpc", bus.if_pc, 32'h1c008000);

        bus.flush_valid = 1; bus.flush_target = 32'hFFFF_FFFB;
        tick(); clear_inputs();
        tick();
        tick(); check("lit_wrap_pre", bus.if_pc, 32'hFFFF_FFF8);
        tick(); check("lit_wrap", bus.if_pc, 32'h0000_0000);

        bus.if_ready = 1'b0;
        tick();
        reset = 1'b1; bus.flush_valid = 1; bus.flush_target = 32'h1c004000;
        tick(); check("lit_rst_stall_valid", 32'(bus.if_valid), 32'd0);
                check("lit_rst_stall_fetch", bus.fetch_pc, 32'h1c000000);
                check("lit_rst_stall_ifpc",  bus.if_pc, 32'd0);
        reset = 1'b0; clear_inputs(); bus.if_ready = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            reset               = ($urandom_range(99) == 0);
            bus.if_ready        = ($urandom_range(9) < 7);
            bus.hit_0           = ($urandom_range(3) == 0);
            bus.hit_1           = ($urandom_range(2) == 0);
            bus.target_0        = $urandom;
            bus.target_1        = $urandom;
            bus.index_0         = IDW'($urandom);
            bus.index_1         = IDW'($urandom);
            bus.flush_valid     = ($urandom_range(15) == 0);
            bus.flush_target    = $urandom;
            bus.branch_mistaken = ($urandom_range(11) == 0);
            bus.right_target    = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
